dp_ram_original: RTL and testbench

- True dual-port synchronous RAM, 2**AWIDTH words of DWIDTH bits.
- Two independent read/write ports (A, B) share one clock.
- Used as an on-chip operand/result buffer in the TPU datapath.
- Registered read data, one-cycle read latency, no handshake.

---
 rtl/dp_ram_original.sv | 85 ++++++++
 tb/tb_dp_ram_original.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dp_ram_original.sv
// dp_ram_original: true dual-port synchronous RAM of 2**AWIDTH words x DWIDTH bits.
// Ports A and B share one clock. Each port can read or write independently.
// Read data is registered, so it appears one cycle after the address is applied.
// There is no handshake: a port acts on every rising clock edge.
//
// Reset is asynchronous and active-high. It clears only the two output
// registers. Memory contents survive reset, and writes are ignored while
// reset is high.
//
// Optional build macro DPRAM_WRITE_THROUGH_EN:
//   undefined (default) - on a write cycle, a port's output holds its previous value.
//   defined             - on a write cycle, a port's output takes the write data
//                         (write-first behaviour).
// In both builds, cross-port read-during-write returns the old data. When both
// ports write the same address in the same cycle, port B's data is stored.

module dp_ram_original #(
  parameter int AWIDTH      = 10,
  parameter int DESIGN_SIZE = 16,
  parameter int DWIDTH      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] address_a,
  input  logic [AWIDTH-1:0] address_b,
  input  logic              wren_a,
  input  logic              wren_b,
  input  logic [DWIDTH-1:0] data_a,
  input  logic [DWIDTH-1:0] data_b,
  output logic [DWIDTH-1:0] out_a,
  output logic [DWIDTH-1:0] out_b
);

  localparam int DEPTH = 2 ** AWIDTH;

  // DESIGN_SIZE describes the surrounding systolic array and does not change
  // RAM behaviour. It is only sanity-checked when the design is elaborated.
  if (DESIGN_SIZE < 1) begin : g_bad_design_size
    $error("dp_ram_original: DESIGN_SIZE must be at least 1");
  end

  // Storage array. It has no reset and no defined power-up contents.
  logic [DWIDTH-1:0] mem [0:DEPTH-1];

  // Array update. Port B's assignment comes last, so port B wins a same-address
  // collision. Both writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wren_a) mem[address_a] <= data_a;
      if (wren_b) mem[address_b] <= data_b;
    end
  end

  // Port A output register. A read samples the array before this edge's writes
  // take effect, so it returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_a <= '0;
    end else if (!wren_a) begin
      out_a <= mem[address_a];
    end else begin
`ifdef DPRAM_WRITE_THROUGH_EN
      out_a <= data_a;
`else
      out_a <= out_a;
`endif
    end
  end

  // Port B output register. Same read and write-cycle rules as port A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_b <= '0;
    end else if (!wren_b) begin
      out_b <= mem[address_b];
    end else begin
`ifdef DPRAM_WRITE_THROUGH_EN
      out_b <= data_b;
`else
      out_b <= out_b;
`endif
    end
  end

endmodule

// File: tb/tb_dp_ram_original.sv
// tb_dp_ram_original: directed bench for dp_ram_original.
// Inputs are applied just after a rising edge, and outputs are sampled 1 ns
// after the following edge. Expected read data comes from hand-computed
// constants and from a bench-side shadow of the memory contents.

module tb_dp_ram_original;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address_a, address_b;
  logic          wren_a, wren_b;
  logic [DW-1:0] data_a, data_b;
  logic [DW-1:0] out_a, out_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [0:(2**AW)-1];
  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] sweep_addr [0:29];

  dp_ram_original #(.AWIDTH(AW), .DESIGN_SIZE(16), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .address_a(address_a), .address_b(address_b),
    .wren_a(wren_a), .wren_b(wren_b),
    .data_a(data_a), .data_b(data_b),
    .out_a(out_a), .out_b(out_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle on both ports, then wait until 1 ns after the edge.
  // When track is set, the shadow memory is updated with any writes. Port B is
  // applied second, so it wins a same-address collision.
  task automatic drive(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input bit track = 1'b1);
    wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db;
    @(posedge clk);
    #1;
    if (track) begin
      if (wa) model_mem[aa] = da;
      if (wb) model_mem[ab] = db;
    end
  endtask

  initial begin
    logic [DW-1:0] hold_exp;
    logic [AW-1:0] n;

    reset = 1'b1;
    wren_a = 1'b0; wren_b = 1'b0;
    address_a = '0; address_b = '0;
    data_a = '0; data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_init_a", out_a, 8'h00);
    check_eq("reset_init_b", out_b, 8'h00);
    reset = 1'b0;

    // basic dual write then read
    drive(1, 10'd5, 8'h11, 1, 10'd6, 8'h22);
    drive(0, 10'd5, 8'h00, 0, 10'd6, 8'h00);
    check_eq("basic_a", out_a, 8'h11);
    check_eq("basic_b", out_b, 8'h22);

    // same-address collision: B wins
    drive(1, 10'h300, 8'h0A, 1, 10'h300, 8'h0B);
`ifdef DPRAM_WRITE_THROUGH_EN
    check_eq("collide_wt_a", out_a, 8'h0A);
    check_eq("collide_wt_b", out_b, 8'h0B);
`endif
    drive(0, 10'h300, 8'h00, 0, 10'h300, 8'h00);
    check_eq("collide_rd_a", out_a, 8'h0B);
    check_eq("collide_rd_b", out_b, 8'h0B);

    // cross-port read during write
    drive(1, 10'd7, 8'h55, 0, 10'd5, 8'h00);
    drive(1, 10'd7, 8'h66, 0, 10'd7, 8'h00);
    check_eq("xport_old_b", out_b, 8'h55);
    drive(0, 10'd5, 8'h00, 0, 10'd7, 8'h00);
    check_eq("xport_new_b", out_b, 8'h66);

    // write-cycle output hold (or write-through)
    drive(1, 10'h020, 8'h44, 0, 10'd6, 8'h00);
    drive(0, 10'h020, 8'h00, 0, 10'd6, 8'h00);
    check_eq("hold_pre_a", out_a, 8'h44);
    drive(1, 10'd9, 8'h77, 0, 10'd6, 8'h00);
`ifdef DPRAM_WRITE_THROUGH_EN
    hold_exp = 8'h77;
`else
    hold_exp = 8'h44;
`endif
    check_eq("hold_wr_a", out_a, hold_exp);
    check_eq("hold_other_b", out_b, 8'h22);
    drive(0, 10'd9, 8'h00, 0, 10'd6, 8'h00);
    check_eq("hold_rd_a", out_a, 8'h77);

    // boundary addresses
    drive(1, 10'd0, 8'hA5, 1, 10'd1023, 8'h5A);
    drive(0, 10'd1023, 8'h00, 0, 10'd0, 8'h00);
    check_eq("bound_1023_a", out_a, 8'h5A);
    check_eq("bound_0_b", out_b, 8'hA5);

    // 30-entry sweep: write random pairs, then read them back in order
    for (int i = 0; i < 30; i++) begin
      n = AW'($urandom_range(0, 1022));
      sweep_addr[i] = n;
      drive(1, n, DW'($urandom_range(0, 255)), 1, n + 10'd1, DW'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 30; i++) begin
      exp_q.push_back(model_mem[sweep_addr[i]]);
      exp_q.push_back(model_mem[sweep_addr[i] + 10'd1]);
      drive(0, sweep_addr[i], 8'h00, 0, sweep_addr[i] + 10'd1, 8'h00);
      check_eq("sweep_a", out_a, exp_q.pop_front());
      check_eq("sweep_b", out_b, exp_q.pop_front());
    end

    // mid-cycle reset: outputs clear at once, memory survives, writes ignored
    drive(1, 10'h040, 8'h3C, 0, 10'd5, 8'h00);
    drive(0, 10'h040, 8'h00, 0, 10'd5, 8'h00);
    check_eq("rst_pre_a", out_a, 8'h3C);
    reset = 1'b1;
    #2;
    check_eq("rst_async_a", out_a, 8'h00);
    check_eq("rst_async_b", out_b, 8'h00);
    drive(1, 10'h040, 8'hFF, 1, 10'h300, 8'hEE, 1'b0);
    check_eq("rst_held_a", out_a, 8'h00);
    check_eq("rst_held_b", out_b, 8'h00);
    reset = 1'b0;
    drive(0, 10'h040, 8'h00, 0, 10'h300, 8'h00);
    check_eq("rst_keep_a", out_a, model_mem[10'h040]);
    check_eq("rst_keep_b", out_b, model_mem[10'h300]);
    check_eq("rst_keep_a_const", out_a, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
